// File: rtl/chip8_pkg.sv
// Shared constants and encodings for the CHIP-8 memory subsystem.
package chip8_pkg;

    localparam int unsigned ADDR_W    = 12;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned RAM_DEPTH = 4096;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_t;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DR  = 1'b1
    } req_idx_t;

endpackage

// File: rtl/chip8_ram.sv
// 4096x8 single-port program/data RAM with a registered, 1-cycle read port.
module chip8_ram
    import chip8_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [RAM_DEPTH];

    // Array has no reset so contents survive a reset of the arbiter.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register only moves on reads, so it holds the last read result.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/chip8_mem_arb.sv
// Loader / CPU / draw-engine arbiter for the CHIP-8 program RAM: BOOT serves the
// loader only, RUN round-robins CPU and draw engine with a bounded CPU lock.
module chip8_mem_arb
    import chip8_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              ld_gnt,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_gnt,
    output logic              dr_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              boot_done
);

    localparam int unsigned       CNT_W      = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]  LOCK_MAX_C = CNT_W'(LOCK_MAX);

    arb_state_t        state;
    arb_state_t        state_nxt;
    req_idx_t          last_q;
    logic [CNT_W-1:0]  lock_cnt;
    logic              lock_hold;
    logic              cpu_rv_q;
    logic              dr_rv_q;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_BOOT && ld_done) begin
            state_nxt = ST_RUN;
        end
    end

    // Grants are gated by reset so nothing reaches the RAM while reset is held.
    always_comb begin
        ld_gnt    = 1'b0;
        cpu_gnt   = 1'b0;
        dr_gnt    = 1'b0;
        boot_done = (state == ST_RUN);
        lock_hold = cpu_lock && (lock_cnt != '0) && (lock_cnt < LOCK_MAX_C);
        if (!reset) begin
            case (state)
                ST_BOOT: ld_gnt = ld_req;
                ST_RUN: begin
                    if (cpu_req && (lock_hold || !dr_req || last_q == REQ_DR)) begin
                        cpu_gnt = 1'b1;
                    end else if (dr_req) begin
                        dr_gnt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // A locked grant at the cap restarts the count, so a lone CPU keeps going
    // while a waiting draw request still wins the cycle after the cap.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q   <= REQ_DR;
            lock_cnt <= '0;
            cpu_rv_q <= 1'b0;
            dr_rv_q  <= 1'b0;
        end else begin
            cpu_rv_q <= cpu_gnt && !cpu_we;
            dr_rv_q  <= dr_gnt;
            if (cpu_gnt) begin
                last_q <= REQ_CPU;
            end else if (dr_gnt) begin
                last_q <= REQ_DR;
            end
            if (cpu_gnt && cpu_lock) begin
                lock_cnt <= (lock_cnt == LOCK_MAX_C) ? CNT_W'(1) : lock_cnt + CNT_W'(1);
            end else begin
                lock_cnt <= '0;
            end
        end
    end

    assign cpu_rvalid = cpu_rv_q && !reset;
    assign dr_rvalid  = dr_rv_q && !reset;

    always_comb begin
        ram_en    = ld_gnt || cpu_gnt || dr_gnt;
        ram_we    = ld_gnt || (cpu_gnt && cpu_we);
        ram_addr  = ld_gnt ? ld_addr : (cpu_gnt ? cpu_addr : dr_addr);
        ram_wdata = ld_gnt ? ld_wdata : cpu_wdata;
    end

    chip8_ram u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_chip8_mem_arb.sv
// Scoreboard bench for chip8_mem_arb: directed grant checks plus a read-response monitor.
module tb_chip8_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_req;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_done;
    logic        ld_gnt;
    logic        cpu_req;
    logic        cpu_we;
    logic        cpu_lock;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic        dr_req;
    logic [11:0] dr_addr;
    logic        dr_gnt;
    logic        dr_rvalid;
    logic [7:0]  rdata;
    logic        boot_done;

    typedef struct {
        bit         port;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    chip8_mem_arb #(.LOCK_MAX(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_done    (ld_done),
        .ld_gnt     (ld_gnt),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_lock   (cpu_lock),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dr_req     (dr_req),
        .dr_addr    (dr_addr),
        .dr_gnt     (dr_gnt),
        .dr_rvalid  (dr_rvalid),
        .rdata      (rdata),
        .boot_done  (boot_done)
    );

    always #5 clk = ~clk;

    // Monitor: every rvalid must match the oldest outstanding expected read.
    always @(negedge clk) begin
        if (cpu_rvalid || dr_rvalid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid cpu_rvalid=%b dr_rvalid=%b required none", cpu_rvalid, dr_rvalid);
            end else begin
                mon_e = sb.pop_front();
                if ((cpu_rvalid && dr_rvalid) || (dr_rvalid != mon_e.port) || (rdata !== mon_e.data)) begin
                    failures++;
                    $display("FAIL read_resp cpu_rvalid=%b dr_rvalid=%b rdata=%h required port=%0d rdata=%h",
                             cpu_rvalid, dr_rvalid, rdata, mon_e.port, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Checks grants for the current input set, queues the expected read data, then advances one cycle.
    task automatic step(input bit e_ld, input bit e_cpu, input bit e_dr,
                        input logic [7:0] e_data, input bit resp, input string nm);
        @(negedge clk);
        chk(nm, {29'b0, ld_gnt, cpu_gnt, dr_gnt}, {29'b0, e_ld, e_cpu, e_dr});
        if (resp && e_cpu && !cpu_we) sb.push_back('{1'b0, e_data});
        if (resp && e_dr) sb.push_back('{1'b1, e_data});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; ld_done = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_lock = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dr_req = 1'b0; dr_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        ld_req = 1'b1; ld_addr = 12'h200; ld_wdata = 8'hA2;
        cpu_req = 1'b1; cpu_addr = 12'h200;
        @(negedge clk);
        chk("rst_gnts", {29'b0, ld_gnt, cpu_gnt, dr_gnt}, 32'd0);
        chk("rst_boot_done", 32'(boot_done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);
        chk("rst_rvalid", {30'b0, cpu_rvalid, dr_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // BOOT: loader alone is served even with the CPU requesting
        step(1, 0, 0, 8'h00, 0, "boot_ld_200");
        ld_addr = 12'h201; ld_wdata = 8'h33;
        step(1, 0, 0, 8'h00, 0, "boot_ld_201");
        ld_addr = 12'h300; ld_wdata = 8'h77;
        step(1, 0, 0, 8'h00, 0, "boot_ld_300");
        ld_addr = 12'h301; ld_wdata = 8'h88;
        step(1, 0, 0, 8'h00, 0, "boot_ld_301");
        ld_req = 1'b0; ld_done = 1'b1; cpu_req = 1'b0;
        step(0, 0, 0, 8'h00, 0, "ld_done_cycle");
        ld_done = 1'b0;
        chk("boot_done_set", 32'(boot_done), 32'd1);

        // RUN: continuous CPU + draw alternate, loader locked out
        ld_req = 1'b1; ld_addr = 12'h400; ld_wdata = 8'hEE;
        cpu_req = 1'b1; cpu_addr = 12'h200; dr_req = 1'b1; dr_addr = 12'h300;
        step(0, 1, 0, 8'hA2, 1, "rr_cpu_1");
        step(0, 0, 1, 8'h77, 1, "rr_dr_1");
        step(0, 1, 0, 8'hA2, 1, "rr_cpu_2");
        step(0, 0, 1, 8'h77, 1, "rr_dr_2");
        ld_req = 1'b0; cpu_req = 1'b0; dr_req = 1'b0;
        step(0, 0, 0, 8'h00, 0, "idle_1");

        cpu_req = 1'b1; cpu_addr = 12'h201;
        step(0, 1, 0, 8'h33, 1, "cpu_alone");
        cpu_req = 1'b0; dr_req = 1'b1; dr_addr = 12'h301;
        step(0, 0, 1, 8'h88, 1, "dr_alone");

        // Lock burst capped at 16 with draw waiting
        cpu_req = 1'b1; cpu_lock = 1'b1; cpu_addr = 12'h200; dr_addr = 12'h300;
        for (int i = 0; i < 16; i++) step(0, 1, 0, 8'hA2, 1, "lock_cpu");
        step(0, 0, 1, 8'h77, 1, "lock_release_dr");
        step(0, 1, 0, 8'hA2, 1, "lock2_first");
        step(0, 1, 0, 8'hA2, 1, "lock2_held");
        cpu_lock = 1'b0;
        step(0, 0, 1, 8'h77, 1, "lock_drop_dr");
        step(0, 1, 0, 8'hA2, 1, "lock_drop_cpu");
        cpu_req = 1'b0; dr_req = 1'b0;
        step(0, 0, 0, 8'h00, 0, "idle_2");

        // Top address write then read-back
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'hFFF; cpu_wdata = 8'h5A;
        step(0, 1, 0, 8'h00, 0, "wr_fff");
        cpu_we = 1'b0;
        step(0, 1, 0, 8'h5A, 1, "rd_fff");
        cpu_req = 1'b0;
        step(0, 0, 0, 8'h00, 0, "idle_3");
        step(0, 0, 0, 8'h00, 0, "idle_4");
        chk("rdata_hold", 32'(rdata), 32'h5A);

        // Reset right after a granted read aborts its response
        cpu_req = 1'b1; cpu_addr = 12'h200;
        step(0, 1, 0, 8'h00, 0, "pre_reset_read");
        reset = 1'b1;
        @(negedge clk);
        chk("rst_abort_rvalid", 32'(cpu_rvalid), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_boot_done_clr", 32'(boot_done), 32'd0);
        step(0, 0, 0, 8'h00, 0, "cpu_blocked");
        ld_done = 1'b1;
        step(0, 0, 0, 8'h00, 0, "cpu_blocked_ld_done");
        ld_done = 1'b0;
        step(0, 1, 0, 8'hA2, 1, "post_reset_read");
        cpu_req = 1'b0;
        step(0, 0, 0, 8'h00, 0, "idle_5");
        step(0, 0, 0, 8'h00, 0, "idle_6");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
